me_result_collector: RTL and testbench
======================================

Name: me_result_collector

Overview:
Consumer of the motion-estimation core's result interface. Samples sad_min/motion_vec_x_min/motion_vec_y_min on each sad_en pulse and tags each result with its macroblock column/row position. Buffers the results in a small FIFO and presents them downstream on a valid/ready stream. Marks the last block of each frame and reports FIFO overflow.

Parameters:
BLK_COLS, 240, macroblocks per row (3840/16)
BLK_ROWS, 135, macroblock rows per frame (2160/16)
DEPTH, 4, FIFO entries (power of two, >=2)
CW, 8, width of blk_x/blk_y fields

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
sad_en  in  1  one-cycle result strobe from core
sad_min  in  14  minimum SAD of current block
motion_vec_x_min  in  4  best x offset
motion_vec_y_min  in  4  best y offset
sync_clr  in  1  synchronous frame resync: flush FIFO, zero block counters
ovf_clr  in  1  synchronous clear of sticky overflow flag
out_valid  out  1  stream word valid
out_ready  in  1  downstream accept
out_data  out  2*CW+22  {blk_y, blk_x, mv_y[3:0], mv_x[3:0], sad[13:0]}, MSB first
out_last  out  1  word is last block of frame
fifo_level  out  clog2(DEPTH)+1  current occupancy
overflow  out  1  sticky: a result was dropped
frame_done  out  1  one-cycle pulse when last word is accepted

Behaviour:
- Reset (async, rst=1): FIFO empty, read/write pointers 0, blk_x=blk_y=0, out_valid=0, out_data=0, out_last=0, fifo_level=0, overflow=0, frame_done=0.
- Push: on a clk edge with sad_en=1, write {blk_y, blk_x, mv_y, mv_x, sad_min} plus last=(blk_x==BLK_COLS-1 && blk_y==BLK_ROWS-1) into the FIFO.
- Block counters advance on every sad_en, whether the push is accepted or dropped. Increment blk_x; at BLK_COLS-1, wrap to 0 and increment blk_y; at the last block, both wrap to 0.
- Pop: handshake = out_valid && out_ready. Pointer advances on that edge.
- out_valid = !empty. out_data/out_last show the head entry and are all-zero when empty.
- Latency: a word pushed at edge N is visible with out_valid=1 after edge N (first-word fall-through, no bypass). Minimum sad_en-to-valid latency is 1 cycle.
- Full, with sad_en=1 and no pop that cycle: word dropped, overflow<=1 (sticky), counters still advance.
- Full, with sad_en=1 and a pop the same cycle: push accepted, level unchanged.
- Empty with sad_en=1: push only (no pop possible); level goes to 1.
- fifo_level = entries held, 0..DEPTH. It is updated on the same edge as a push or pop.
- frame_done: registered; 1 for exactly one cycle after the edge where a word with last=1 is handshaked.
- sync_clr=1: same effect as reset for the FIFO, counters, out_valid, out_data and frame_done, but overflow is kept. A sad_en in the same cycle is discarded. sync_clr has priority over sad_en and pop.
- ovf_clr=1: overflow<=0. If a drop happens in the same cycle, overflow<=1 (set wins).
- out_ready may toggle freely. out_data must stay stable while out_valid=1 and out_ready=0.
- Core rate: one sad_en per 25 cycles. A 4-entry FIFO therefore absorbs 75+ cycles of stall without loss.

Test Plan:
- Reset then single result: sad_en with sad_min=14'h0123, x=3, y=5, out_ready=1 → next cycle out_valid=1, out_data={8'd0,8'd0,4'd5,4'd3,14'h0123}, fifo_level=1; after handshake fifo_level=0.
- Raster indexing, BLK_COLS=4, BLK_ROWS=2: 8 sad_en pulses → tags (0,0)…(3,0),(0,1)…(3,1); out_last=1 only on the 8th word; frame_done pulses once; the 9th pulse is tagged (0,0).
- Backpressure/overflow, DEPTH=4, out_ready=0: 5 sad_en pulses 25 cycles apart → fifo_level=4, overflow=1, the 5th result is absent. The 6th pulse is tagged blk_x=5 (counter advanced past the drop); ovf_clr → overflow=0.
- Full with simultaneous push and pop: FIFO at 4 entries, sad_en and out_ready=1 in the same cycle → level stays 4, head advances, overflow stays 0.
- sync_clr with 3 entries held and sad_en high → next cycle fifo_level=0, out_valid=0, blk_x=blk_y=0, the concurrent sad_en is not stored, overflow is unchanged.
- Async reset asserted mid-stream, between clock edges → out_valid and fifo_level go to 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/me_result_collector.sv
// me_result_collector: captures motion-estimation results on each sad_en strobe,
// tags them with the macroblock raster position, buffers them in a small
// first-word-fall-through FIFO and streams them out on a valid/ready interface.
module me_result_collector #(
    parameter int unsigned BLK_COLS = 240,
    parameter int unsigned BLK_ROWS = 135,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned CW       = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sad_en,
    input  logic [13:0]               sad_min,
    input  logic [3:0]                motion_vec_x_min,
    input  logic [3:0]                motion_vec_y_min,
    input  logic                      sync_clr,
    input  logic                      ovf_clr,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [2*CW+21:0]          out_data,
    output logic                      out_last,
    output logic [$clog2(DEPTH):0]    fifo_level,
    output logic                      overflow,
    output logic                      frame_done
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned DW = 2 * CW + 22;

    // Each entry stores {last, data}
    logic [DW:0]    mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    level_q, level_d;
    logic [CW-1:0]  blk_x_q, blk_x_d;
    logic [CW-1:0]  blk_y_q, blk_y_d;
    logic           overflow_q, overflow_d;
    logic           frame_done_q, frame_done_d;

    logic           empty, full;
    logic           push, pop, drop;
    logic           last_col, last_blk;
    logic [DW:0]    head;
    logic [DW:0]    wr_entry;

    assign empty    = (level_q == '0);
    assign full     = (level_q == (AW + 1)'(DEPTH));
    assign last_col = (blk_x_q == CW'(BLK_COLS - 1));
    assign last_blk = last_col && (blk_y_q == CW'(BLK_ROWS - 1));
    assign head     = mem_q[rd_ptr_q];
    assign wr_entry = {last_blk, blk_y_q, blk_x_q, motion_vec_y_min, motion_vec_x_min, sad_min};

    // sync_clr overrides both sides of the FIFO; a full FIFO still accepts a
    // push when the head leaves in the same cycle.
    assign pop  = !empty && out_ready && !sync_clr;
    assign push = sad_en && !sync_clr && (!full || pop);
    assign drop = sad_en && !sync_clr && full && !pop;

    // Next-state for pointers, occupancy, raster counters and status flags
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        blk_x_d      = blk_x_q;
        blk_y_d      = blk_y_q;
        overflow_d   = overflow_q;
        frame_done_d = 1'b0;

        if (sync_clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            blk_x_d  = '0;
            blk_y_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d     = rd_ptr_q + AW'(1);
                frame_done_d = head[DW];
            end
            unique case ({push, pop})
                2'b10:   level_d = level_q + (AW + 1)'(1);
                2'b01:   level_d = level_q - (AW + 1)'(1);
                default: level_d = level_q;
            endcase
            // Counters track every strobe, so dropped results still consume a position
            if (sad_en) begin
                if (last_blk) begin
                    blk_x_d = '0;
                    blk_y_d = '0;
                end else if (last_col) begin
                    blk_x_d = '0;
                    blk_y_d = blk_y_q + CW'(1);
                end else begin
                    blk_x_d = blk_x_q + CW'(1);
                end
            end
        end

        // A drop in the same cycle as ovf_clr keeps the flag set
        if (drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    // Control state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            blk_x_q      <= '0;
            blk_y_q      <= '0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            blk_x_q      <= blk_x_d;
            blk_y_q      <= blk_y_d;
            overflow_q   <= overflow_d;
            frame_done_q <= frame_done_d;
        end
    end

    // FIFO storage; contents are masked at the output while empty, so no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    // Stream outputs: head entry when occupied, all-zero otherwise
    always_comb begin
        out_valid  = !empty;
        out_data   = empty ? '0 : head[DW-1:0];
        out_last   = empty ? 1'b0 : head[DW];
        fifo_level = level_q;
        overflow   = overflow_q;
        frame_done = frame_done_q;
    end

endmodule

// File: tb/tb_me_result_collector.sv
// Directed testbench for me_result_collector using a 4x2 block frame and a 4-entry FIFO.
module tb_me_result_collector;

    localparam int unsigned BLK_COLS = 4;
    localparam int unsigned BLK_ROWS = 2;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned CW       = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        sad_en;
    logic [13:0] sad_min;
    logic [3:0]  motion_vec_x_min;
    logic [3:0]  motion_vec_y_min;
    logic        sync_clr;
    logic        ovf_clr;
    logic        out_valid;
    logic        out_ready;
    logic [37:0] out_data;
    logic        out_last;
    logic [2:0]  fifo_level;
    logic        overflow;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    me_result_collector #(
        .BLK_COLS (BLK_COLS),
        .BLK_ROWS (BLK_ROWS),
        .DEPTH    (DEPTH),
        .CW       (CW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .sad_en           (sad_en),
        .sad_min          (sad_min),
        .motion_vec_x_min (motion_vec_x_min),
        .motion_vec_y_min (motion_vec_y_min),
        .sync_clr         (sync_clr),
        .ovf_clr          (ovf_clr),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .out_last         (out_last),
        .fifo_level       (fifo_level),
        .overflow         (overflow),
        .frame_done       (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] sad;
        logic [3:0]  mvx;
        logic [3:0]  mvy;
        logic [7:0]  x;
        logic [7:0]  y;
        logic        last;
    } vec_t;

    vec_t vecs [9];

    function automatic logic [37:0] word(input logic [7:0] y, input logic [7:0] x,
                                         input logic [3:0] my, input logic [3:0] mx,
                                         input logic [13:0] s);
        return {y, x, my, mx, s};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse(input logic [13:0] s, input logic [3:0] mx, input logic [3:0] my,
                         input logic rdy, input logic oc, input logic sc);
        sad_en           = 1'b1;
        sad_min          = s;
        motion_vec_x_min = mx;
        motion_vec_y_min = my;
        out_ready        = rdy;
        ovf_clr          = oc;
        sync_clr         = sc;
        tick();
        sad_en    = 1'b0;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
        sync_clr  = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        vecs[0] = '{14'h0123, 4'd3, 4'd5, 8'd0, 8'd0, 1'b0};
        vecs[1] = '{14'h0001, 4'd1, 4'd2, 8'd1, 8'd0, 1'b0};
        vecs[2] = '{14'h3fff, 4'hf, 4'h0, 8'd2, 8'd0, 1'b0};
        vecs[3] = '{14'h2aaa, 4'ha, 4'h5, 8'd3, 8'd0, 1'b0};
        vecs[4] = '{14'h1555, 4'h5, 4'ha, 8'd0, 8'd1, 1'b0};
        vecs[5] = '{14'h0000, 4'h0, 4'hf, 8'd1, 8'd1, 1'b0};
        vecs[6] = '{14'h0abc, 4'h7, 4'h8, 8'd2, 8'd1, 1'b0};
        vecs[7] = '{14'h1234, 4'h9, 4'h6, 8'd3, 8'd1, 1'b1};
        vecs[8] = '{14'h0777, 4'h4, 4'h4, 8'd0, 8'd0, 1'b0};

        rst = 1'b1; sad_en = 1'b0; sad_min = '0; motion_vec_x_min = '0;
        motion_vec_y_min = '0; sync_clr = 1'b0; ovf_clr = 1'b0; out_ready = 1'b0;
        #1;
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset fifo_level", 64'(fifo_level), 64'd0);
        check("reset out_data", 64'(out_data), 64'd0);
        check("reset out_last", 64'(out_last), 64'd0);
        check("reset overflow", 64'(overflow), 64'd0);
        check("reset frame_done", 64'(frame_done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Raster indexing across a whole frame plus the first block of the next
        for (int i = 0; i < 9; i++) begin
            pulse(vecs[i].sad, vecs[i].mvx, vecs[i].mvy, 1'b0, 1'b0, 1'b0);
            check($sformatf("raster[%0d] valid", i), 64'(out_valid), 64'd1);
            check($sformatf("raster[%0d] data", i), 64'(out_data),
                  64'(word(vecs[i].y, vecs[i].x, vecs[i].mvy, vecs[i].mvx, vecs[i].sad)));
            check($sformatf("raster[%0d] last", i), 64'(out_last), 64'(vecs[i].last));
            check($sformatf("raster[%0d] level", i), 64'(fifo_level), 64'd1);
            pop_one();
            check($sformatf("raster[%0d] level after pop", i), 64'(fifo_level), 64'd0);
            check($sformatf("raster[%0d] frame_done", i), 64'(frame_done), 64'(vecs[i].last));
            if (vecs[i].last) begin
                tick();
                check($sformatf("raster[%0d] frame_done one cycle", i), 64'(frame_done), 64'd0);
            end
        end

        // Backpressure and overflow: fifth result dropped, counters keep counting
        sync_clr = 1'b1;
        tick();
        sync_clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pulse(14'(16'h0200 + i), 4'(i), 4'(15 - i), 1'b0, 1'b0, 1'b0);
            repeat (24) tick();
        end
        check("ovf level", 64'(fifo_level), 64'd4);
        check("ovf flag", 64'(overflow), 64'd1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ovf pop[%0d] data", i), 64'(out_data),
                  64'(word(8'd0, 8'(i), 4'(15 - i), 4'(i), 14'(16'h0200 + i))));
            pop_one();
        end
        check("ovf fifth absent", 64'(out_valid), 64'd0);
        pulse(14'h03ab, 4'd6, 4'd7, 1'b0, 1'b0, 1'b0);
        check("ovf sixth tag", 64'(out_data), 64'(word(8'd1, 8'd1, 4'd7, 4'd6, 14'h03ab)));
        pop_one();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_clr", 64'(overflow), 64'd0);

        // Full FIFO with push and pop in the same cycle
        for (int i = 0; i < 4; i++) begin
            pulse(14'(16'h0010 + i), 4'd1, 4'd1, 1'b0, 1'b0, 1'b0);
        end
        check("full level", 64'(fifo_level), 64'd4);
        pulse(14'h0014, 4'd1, 4'd1, 1'b1, 1'b0, 1'b0);
        check("push+pop level", 64'(fifo_level), 64'd4);
        check("push+pop overflow", 64'(overflow), 64'd0);
        check("push+pop head", 64'(out_data), 64'(word(8'd1, 8'd3, 4'd1, 4'd1, 14'h0011)));
        check("push+pop head last", 64'(out_last), 64'd1);
        check("push+pop frame_done", 64'(frame_done), 64'd0);

        // Drop coinciding with ovf_clr: set wins
        pulse(14'h0015, 4'd1, 4'd1, 1'b0, 1'b1, 1'b0);
        check("set wins overflow", 64'(overflow), 64'd1);
        check("set wins level", 64'(fifo_level), 64'd4);
        pop_one();
        check("last pop frame_done", 64'(frame_done), 64'd1);
        check("last pop level", 64'(fifo_level), 64'd3);
        check("last pop head", 64'(out_data), 64'(word(8'd0, 8'd0, 4'd1, 4'd1, 14'h0012)));

        // sync_clr with 3 entries held and a concurrent strobe
        pulse(14'h0016, 4'd2, 4'd2, 1'b0, 1'b0, 1'b1);
        check("sync_clr level", 64'(fifo_level), 64'd0);
        check("sync_clr valid", 64'(out_valid), 64'd0);
        check("sync_clr data", 64'(out_data), 64'd0);
        check("sync_clr overflow kept", 64'(overflow), 64'd1);
        pulse(14'h0055, 4'd3, 4'd4, 1'b0, 1'b0, 1'b0);
        check("sync_clr counters zero", 64'(out_data), 64'(word(8'd0, 8'd0, 4'd4, 4'd3, 14'h0055)));
        check("sync_clr level after push", 64'(fifo_level), 64'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_clr after sync", 64'(overflow), 64'd0);

        // Asynchronous reset between clock edges
        pulse(14'h0066, 4'd5, 4'd6, 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("async rst valid", 64'(out_valid), 64'd0);
        check("async rst level", 64'(fifo_level), 64'd0);
        check("async rst data", 64'(out_data), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        pulse(14'h0077, 4'd8, 4'd9, 1'b0, 1'b0, 1'b0);
        check("post rst tag", 64'(out_data), 64'(word(8'd0, 8'd0, 4'd9, 4'd8, 14'h0077)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
